// File: rtl/out_buffer_pkg.sv
// Shared definitions for the output buffer: FSM state encoding, default
// capacity and the all-bytes-valid stream strobe.
package out_buffer_pkg;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_SEND    = 1'b1
  } state_t;

  localparam int         OUT_DEPTH     = 576;   // 32-bit words (2304 bytes)
  localparam logic [3:0] AXIS_STRB_ALL = 4'hF;

endpackage

// File: rtl/out_ram.sv
// Simple dual-port word store for the output buffer.
//   clk          : clock, rising edge
//   we/waddr/wdata : write port
//   re/raddr     : read request; rdata is registered (valid one cycle later)
// Contents are never reset.
module out_ram
  import out_buffer_pkg::*;
#(
  parameter int DEPTH = OUT_DEPTH,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/out_buffer.sv
// Output buffer: collects PE result words into a RAM, then streams them out
// as one AXI-Stream packet on flush (or automatically when full).
//   clk, rst          : clock, synchronous active-high reset
//   i_pe_data/valid   : PE words in; o_pe_ready while collecting with room
//   i_flush           : start transmitting the buffered words
//   m_axis_*          : stream out (tdata, tstrb, tlast, tvalid, tready)
//   o_send_done       : pulse on the tlast handshake
//   o_overflow        : sticky, a PE word was dropped
module out_buffer
  import out_buffer_pkg::*;
#(
  parameter int DEPTH = OUT_DEPTH,
  parameter int AW    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_pe_data,
  input  logic        i_pe_valid,
  output logic        o_pe_ready,
  input  logic        i_flush,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tstrb,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        o_send_done,
  output logic        o_overflow
);

  // One extra bit so the counters can hold DEPTH itself.
  localparam int            CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t        state, state_nxt;
  logic [CW-1:0] wr_cnt, pkt_len, rd_ptr;
  logic          wr_en, rd_en, rd_pend, rd_pend_last;
  logic          pop, send_last;
  logic [31:0]   rdata;
  logic [31:0]   h_data, s_data;   // head (drives the stream) and skid entry
  logic          h_last, s_last;
  logic [1:0]    occ;
  logic [2:0]    occ_nxt;

  assign o_pe_ready = (state == ST_COLLECT) && (wr_cnt < DEPTH_C);
  assign wr_en      = i_pe_valid && o_pe_ready;
  assign pop        = m_axis_tvalid && m_axis_tready;
  assign send_last  = pop && h_last;

  // A read issued now lands in the output stage one edge later; only issue
  // if that word is guaranteed a slot, counting the read already in flight.
  assign occ_nxt = 3'(occ) - 3'(pop) + 3'(rd_pend);
  assign rd_en   = (state == ST_SEND) && (rd_ptr < pkt_len) && (occ_nxt < 3'd2);

  out_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_cnt[AW-1:0]),
    .wdata (i_pe_data),
    .re    (rd_en),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata)
  );

  // FSM
  always_ff @(posedge clk) begin
    if (rst) state <= ST_COLLECT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_COLLECT:
        // A word written in the flush cycle counts toward a non-empty buffer.
        if (wr_cnt == DEPTH_C || (i_flush && (wr_cnt != '0 || wr_en)))
          state_nxt = ST_SEND;
      ST_SEND:
        if (send_last) state_nxt = ST_COLLECT;
      default: state_nxt = ST_COLLECT;
    endcase
  end

  // Counters, packet length, overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt     <= '0;
      pkt_len    <= '0;
      rd_ptr     <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (i_pe_valid && !o_pe_ready) o_overflow <= 1'b1;
      if (state == ST_COLLECT) begin
        if (wr_en) wr_cnt <= wr_cnt + CW'(1);
        if (state_nxt == ST_SEND) begin
          pkt_len <= wr_cnt + CW'(wr_en);
          rd_ptr  <= '0;
        end
      end else begin
        if (rd_en)     rd_ptr <= rd_ptr + CW'(1);
        if (send_last) wr_cnt <= '0;
      end
    end
  end

  // Read-in-flight tracking; last flag travels with the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
    end else begin
      rd_pend      <= rd_en;
      rd_pend_last <= rd_en && (rd_ptr == pkt_len - CW'(1));
    end
  end

  // 2-entry output stage: head holds steady while stalled, skid catches the
  // word already read from RAM when the sink stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ    <= '0;
      h_data <= '0;
      h_last <= 1'b0;
      s_data <= '0;
      s_last <= 1'b0;
    end else begin
      case ({rd_pend, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            h_data <= rdata;
            h_last <= rd_pend_last;
          end else begin
            s_data <= rdata;
            s_last <= rd_pend_last;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          h_data <= s_data;
          h_last <= s_last;
          occ    <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            h_data <= rdata;
            h_last <= rd_pend_last;
          end else begin
            h_data <= s_data;
            h_last <= s_last;
            s_data <= rdata;
            s_last <= rd_pend_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_axis_tvalid = (occ != 2'd0);
  assign m_axis_tdata  = h_data;
  assign m_axis_tlast  = m_axis_tvalid && h_last;
  assign m_axis_tstrb  = m_axis_tvalid ? AXIS_STRB_ALL : 4'h0;
  assign o_send_done   = send_last;

endmodule

// File: tb/tb_out_buffer.sv
// Directed bench for out_buffer: per-cycle vector table for the short
// packets, plus a hand-written sequence for the full-buffer auto send.
module tb_out_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_pe_data;
  logic        i_pe_valid;
  logic        o_pe_ready;
  logic        i_flush;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tstrb;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        o_send_done;
  logic        o_overflow;

  always #5 clk = ~clk;

  out_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .i_pe_data     (i_pe_data),
    .i_pe_valid    (i_pe_valid),
    .o_pe_ready    (o_pe_ready),
    .i_flush       (i_flush),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .o_send_done   (o_send_done),
    .o_overflow    (o_overflow)
  );

  // Inputs for one cycle and the outputs expected in that same cycle
  // (before the edge that consumes the inputs).
  typedef struct {
    logic        rst, v;
    logic [31:0] d;
    logic        fl, rdy;
    logic        e_rdy, e_vld;
    logic [31:0] e_data;
    logic        e_last, e_done, e_ovf, dchk;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic row(input logic rst_, v_, input logic [31:0] d_,
                     input logic fl_, rdy_, e_rdy_, e_vld_,
                     input logic [31:0] e_data_,
                     input logic e_last_, e_done_, e_ovf_, dchk_);
    vec_t r;
    r.rst = rst_; r.v = v_; r.d = d_; r.fl = fl_; r.rdy = rdy_;
    r.e_rdy = e_rdy_; r.e_vld = e_vld_; r.e_data = e_data_;
    r.e_last = e_last_; r.e_done = e_done_; r.e_ovf = e_ovf_; r.dchk = dchk_;
    vq.push_back(r);
  endtask

  task automatic wr(input logic [31:0] d, input logic ovf);
    row(0, 1, d, 0, 1, 1, 0, 32'h0, 0, 0, ovf, 0);
  endtask

  task automatic flush(input logic ovf);
    row(0, 0, 32'h0, 1, 1, 1, 0, 32'h0, 0, 0, ovf, 0);
  endtask

  task automatic idle(input logic rdy_in, e_rdy, ovf);
    row(0, 0, 32'h0, 0, rdy_in, e_rdy, 0, 32'h0, 0, 0, ovf, 0);
  endtask

  task automatic beat(input logic rdy_in, input logic [31:0] d,
                      input logic last, done, ovf);
    row(0, 0, 32'h0, 0, rdy_in, 0, 1, d, last, done, ovf, 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0]  act, exp;
    logic        ok, bad, dbad, rbad;
    int          beats, dones, lastpos;

    // Packet of 4, tready high: tvalid two edges after the flush edge.
    row(0, 0, 32'h0, 0, 1, 1, 0, 32'h0, 0, 0, 0, 1);     // reset state, tdata 0
    for (int k = 0; k < 4; k++) wr(32'h0102_0304 + 32'(4 * k), 0);
    flush(0);
    idle(1, 0, 0);
    idle(1, 0, 0);
    for (int k = 0; k < 4; k++)
      beat(1, 32'h0102_0304 + 32'(4 * k), k == 3, k == 3, 0);
    idle(1, 1, 0);

    // Flush on empty buffer is ignored; write+flush same cycle on empty.
    flush(0);
    idle(1, 1, 0);
    row(0, 1, 32'hA5A5_0001, 1, 1, 1, 0, 32'h0, 0, 0, 0, 0);
    idle(1, 0, 0);
    idle(1, 0, 0);
    beat(1, 32'hA5A5_0001, 1, 1, 0);
    idle(1, 1, 0);

    // 8 words, tready alternating 1/0: each word held through its stall.
    for (int k = 0; k < 8; k++) wr(32'hB000_0000 + 32'(k), 0);
    flush(0);
    idle(1, 0, 0);
    idle(0, 0, 0);
    beat(1, 32'hB000_0000, 0, 0, 0);
    for (int k = 1; k < 8; k++) begin
      beat(0, 32'hB000_0000 + 32'(k), k == 7, 0, 0);
      beat(1, 32'hB000_0000 + 32'(k), k == 7, k == 7, 0);
    end
    idle(1, 1, 0);

    // Write during SEND is dropped and sets the sticky overflow flag.
    wr(32'hC000_0000, 0);
    wr(32'hC000_0001, 0);
    flush(0);
    row(0, 1, 32'hDEAD_BEEF, 0, 1, 0, 0, 32'h0, 0, 0, 0, 0);
    idle(1, 0, 1);
    beat(1, 32'hC000_0000, 0, 0, 1);
    beat(1, 32'hC000_0001, 1, 1, 1);
    idle(1, 1, 1);

    // Reset after beat 3 of 8, then a clean 2-word packet.
    for (int k = 0; k < 8; k++) wr(32'hE000_0000 + 32'(k), 1);
    flush(1);
    idle(1, 0, 1);
    idle(1, 0, 1);
    for (int k = 0; k < 3; k++) beat(1, 32'hE000_0000 + 32'(k), 0, 0, 1);
    row(1, 0, 32'h0, 0, 0, 0, 1, 32'hE000_0003, 0, 0, 1, 0);
    row(0, 0, 32'h0, 0, 1, 1, 0, 32'h0, 0, 0, 0, 1);
    wr(32'hF000_0000, 0);
    wr(32'hF000_0001, 0);
    flush(0);
    idle(1, 0, 0);
    idle(1, 0, 0);
    beat(1, 32'hF000_0000, 0, 0, 0);
    beat(1, 32'hF000_0001, 1, 1, 0);
    idle(1, 1, 0);

    rst = 1'b1; i_pe_valid = 1'b0; i_pe_data = '0; i_flush = 1'b0;
    m_axis_tready = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].rst; i_pe_valid = vq[i].v; i_pe_data = vq[i].d;
      i_flush = vq[i].fl; m_axis_tready = vq[i].rdy;
      #1;
      act = {o_pe_ready, m_axis_tvalid, m_axis_tlast, o_send_done, o_overflow,
             m_axis_tstrb};
      exp = {vq[i].e_rdy, vq[i].e_vld, vq[i].e_last, vq[i].e_done, vq[i].e_ovf,
             vq[i].e_vld ? 4'hF : 4'h0};
      ok = (act === exp) &&
           (!(vq[i].dchk || vq[i].e_vld) || (m_axis_tdata === vq[i].e_data));
      n_vec++;
      if (!ok) begin
        n_bad++;
        $display("FAIL vec%0d: rdy,vld,last,done,ovf,strb=%b tdata=%h, want %b tdata=%h",
                 i, act, m_axis_tdata, exp, vq[i].e_data);
      end
    end

    // Fill all 576 words with no flush; the 577th write is dropped.
    bad = 1'b0;
    i_flush = 1'b0; m_axis_tready = 1'b1; rst = 1'b0;
    for (int i = 0; i < 576; i++) begin
      @(negedge clk);
      i_pe_valid = 1'b1; i_pe_data = 32'h1000_0000 + 32'(i);
      #1;
      if (o_pe_ready !== 1'b1) bad = 1'b1;
    end
    chk("fill_ready", 32'(bad), 32'd0);
    @(negedge clk);
    i_pe_data = 32'hDEAD_BEEF;
    #1;
    chk("full_ready", 32'(o_pe_ready), 32'd0);
    @(negedge clk);
    i_pe_valid = 1'b0;
    #1;
    chk("full_overflow", 32'(o_overflow), 32'd1);
    chk("auto_send_ready", 32'(o_pe_ready), 32'd0);

    beats = 0; dones = 0; lastpos = -1; dbad = 1'b0; rbad = 1'b0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      #1;
      if (o_send_done) dones++;
      if (m_axis_tvalid) begin
        if (o_pe_ready !== 1'b0) rbad = 1'b1;
        if (m_axis_tdata !== 32'h1000_0000 + 32'(beats)) dbad = 1'b1;
        if (m_axis_tlast) lastpos = beats;
        beats++;
        if (m_axis_tlast) break;
      end
    end
    chk("auto_beats", 32'(beats), 32'd576);
    chk("auto_order", 32'(dbad), 32'd0);
    chk("auto_tlast_pos", 32'(lastpos), 32'd575);
    chk("auto_send_done", 32'(dones), 32'd1);
    chk("auto_ready_low", 32'(rbad), 32'd0);
    @(negedge clk);
    #1;
    chk("post_ready", 32'(o_pe_ready), 32'd1);
    chk("post_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("post_overflow", 32'(o_overflow), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/out_buffer.md
OUT_BUFFER -- requirements
Module: out_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 576, meaning buffer capacity in 32-bit words (2304 bytes).
REQ-002 SHALL have parameter AW, default 10, meaning address width, with 2^AW >= DEPTH.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port i_pe_data, input, 32, PE result word (byte 3 = first pixel).
REQ-006 SHALL have port i_pe_valid, input, 1, i_pe_data valid this cycle.
REQ-007 SHALL have port o_pe_ready, output, 1, buffer accepts PE words.
REQ-008 SHALL have port i_flush, input, 1, single-cycle request to transmit the buffered words.
REQ-009 SHALL have port m_axis_tdata, output, 32, stream data.
REQ-010 SHALL have port m_axis_tstrb, output, 4, byte strobes.
REQ-011 SHALL have port m_axis_tlast, output, 1, last word of packet.
REQ-012 SHALL have port m_axis_tvalid, output, 1, stream data valid.
REQ-013 SHALL have port m_axis_tready, input, 1, DMA ready.
REQ-014 SHALL have port o_send_done, output, 1, one-cycle pulse on the tlast handshake.
REQ-015 SHALL have port o_overflow, output, 1, sticky flag: a word was dropped.

Function
REQ-016 SHALL implement FSM COLLECT -> SEND -> COLLECT; COLLECT after reset.
REQ-017 COLLECT: o_pe_ready=1 while wr_cnt<DEPTH; each i_pe_valid&&o_pe_ready writes word at address wr_cnt, wr_cnt+1.
REQ-018 i_pe_valid while wr_cnt==DEPTH or in SEND SHALL drop the word and set o_overflow until reset.
REQ-019 COLLECT->SEND on i_flush with wr_cnt>0, or automatically the cycle after wr_cnt reaches DEPTH; i_flush with wr_cnt==0 ignored.
REQ-020 i_pe_valid and i_flush in the same cycle: word written first and included in the packet.
REQ-021 SEND: o_pe_ready=0; words read in address order 0..wr_cnt-1, packet length latched at entry to SEND.
REQ-022 RAM read latency 1 cycle; first m_axis_tvalid SHALL rise exactly 2 cycles after the accepted i_flush edge.
REQ-023 m_axis_tdata/tlast SHALL hold stable while tvalid&&!tready; tvalid never drops before handshake.
REQ-024 With tready held high, one word per cycle SHALL transfer (no bubbles); a 2-entry skid/output stage absorbs RAM latency.
REQ-025 m_axis_tstrb SHALL be 4'hF whenever tvalid=1, else 4'h0.
REQ-026 m_axis_tlast=1 only on word index len-1; a 1-word packet has tlast on its only word.
REQ-027 On the tlast handshake: o_send_done=1 for one cycle, wr_cnt<=0, state<=COLLECT; o_pe_ready=1 next cycle.
REQ-028 i_flush during SEND SHALL be ignored.

Reset
REQ-029 rst SHALL set state=COLLECT, wr_cnt=0, read pointers 0, skid empty; effective the next edge, including mid-packet.
REQ-030 Reset values: m_axis_tvalid=0, tlast=0, tdata=0, tstrb=0, o_send_done=0, o_overflow=0, o_pe_ready=1 after first clock.
REQ-031 RAM contents SHALL NOT be reset; no partial packet continues after reset.

Structure
REQ-032 Shared package SHALL hold FSM state encodings, DEPTH default (576) and AXIS_STRB_ALL (4'hF).
REQ-033 Storage SHALL be one sub-module out_ram: simple dual-port, DEPTH x 32, 1-cycle registered read.
REQ-034 FSM, counters and skid stage SHALL reside in out_buffer.

Verification
REQ-035 Write 0x01020304..+4 words ×4, i_flush, tready=1 -> 4 beats in order, tvalid 2 cycles after flush, tlast on beat 4, o_send_done once.
REQ-036 576 writes, no flush, tready=1 -> auto send of 576 beats, tlast on beat 576, o_pe_ready=0 during SEND.
REQ-037 8 words, tready toggled 1/0 every cycle -> 8 beats, data stable while stalled, no loss/duplication.
REQ-038 Write during SEND and 577th write -> word dropped, o_overflow=1 until rst.
REQ-039 rst asserted after beat 3 of 8 -> tvalid=0 next cycle, new 2-word packet sent cleanly, tlast on beat 2.
REQ-040 i_flush with empty buffer -> no tvalid; i_pe_valid+i_flush same cycle on empty -> 1-beat packet with tlast=1.
